// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that time-shares one combinational FPU between NREQ requesters.
// Operands are latched and held for an op-dependent number of cycles before the result is captured.
module fpu_arbiter #(
   parameter int NREQ        = 4,
   parameter int BASE_CYCLES = 2,
   parameter int FMA_CYCLES  = 3,
   parameter int DIV_CYCLES  = 6
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [NREQ-1:0]     REQ_VALID,
   output logic [NREQ-1:0]     REQ_READY,
   input  logic [32*NREQ-1:0]  REQ_DATA1,
   input  logic [32*NREQ-1:0]  REQ_DATA2,
   input  logic [32*NREQ-1:0]  REQ_DATA3,
   input  logic [5*NREQ-1:0]   REQ_SELECT,
   output logic [NREQ-1:0]     RESP_VALID,
   input  logic [NREQ-1:0]     RESP_READY,
   output logic [31:0]         RESP_RESULT,
   output logic [31:0]         FPU_DATA1,
   output logic [31:0]         FPU_DATA2,
   output logic [31:0]         FPU_DATA3,
   output logic [4:0]          FPU_SELECT,
   input  logic [31:0]         FPU_RESULT,
   output logic                BUSY
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] grant;
   logic [PW-1:0] win;
   logic [PW-1:0] cand;
   logic [PW:0]   sum;
   logic          found;
   logic [3:0]    count;
   logic [31:0]   win_data1;
   logic [31:0]   win_data2;
   logic [31:0]   win_data3;
   logic [4:0]    win_select;

   // Execute length of an op; anything not divide or fused uses the base length.
   function automatic logic [3:0] exec_len(input logic [4:0] sel);
      case (sel)
         5'b00100:                               exec_len = 4'(DIV_CYCLES);
         5'b01110, 5'b01111, 5'b10000, 5'b10001: exec_len = 4'(FMA_CYCLES);
         default:                                exec_len = 4'(BASE_CYCLES);
      endcase
   endfunction

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      sum   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(NREQ)) begin
            cand = PW'(sum - (PW+1)'(NREQ));
         end else begin
            cand = sum[PW-1:0];
         end
         if (!found && REQ_VALID[cand]) begin
            found = 1'b1;
            win   = cand;
         end else begin
            found = found;
         end
      end
   end

   // Operand mux selecting the winning requester's slice.
   always_comb begin
      win_data1  = 32'd0;
      win_data2  = 32'd0;
      win_data3  = 32'd0;
      win_select = 5'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            win_data1  = REQ_DATA1[32*i +: 32];
            win_data2  = REQ_DATA2[32*i +: 32];
            win_data3  = REQ_DATA3[32*i +: 32];
            win_select = REQ_SELECT[5*i +: 5];
         end else begin
            win_select = win_select;
         end
      end
   end

   // Handshake outputs decoded from the state register and the latched grant.
   always_comb begin
      REQ_READY  = '0;
      RESP_VALID = '0;
      if (state == IDLE && found) begin
         REQ_READY[win] = 1'b1;
      end else begin
         REQ_READY = '0;
      end
      if (state == RESP) begin
         RESP_VALID[grant] = 1'b1;
      end else begin
         RESP_VALID = '0;
      end
   end

   assign BUSY = (state != IDLE);

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (found) next_state = EXEC;
            else       next_state = IDLE;
         end
         EXEC: begin
            if (count == 4'd0) next_state = RESP;
            else               next_state = EXEC;
         end
         RESP: begin
            if (RESP_READY[grant]) next_state = IDLE;
            else                   next_state = RESP;
         end
         default: next_state = IDLE;
      endcase
   end

   // State, pointer, operand hold registers and result capture.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         ptr         <= '0;
         grant       <= '0;
         count       <= 4'd0;
         FPU_DATA1   <= 32'd0;
         FPU_DATA2   <= 32'd0;
         FPU_DATA3   <= 32'd0;
         FPU_SELECT  <= 5'd0;
         RESP_RESULT <= 32'd0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (found) begin
                  grant      <= win;
                  FPU_DATA1  <= win_data1;
                  FPU_DATA2  <= win_data2;
                  FPU_DATA3  <= win_data3;
                  FPU_SELECT <= win_select;
                  count      <= exec_len(win_select) - 4'd1;
                  if (win == PW'(NREQ - 1)) ptr <= '0;
                  else                      ptr <= win + PW'(1);
               end
            end
            EXEC: begin
               if (count == 4'd0) RESP_RESULT <= FPU_RESULT;
               else               count <= count - 4'd1;
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter with a small table-driven FPU model.
module tb_fpu_arbiter;

   localparam int NREQ = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [32*NREQ-1:0] req_data1;
   logic [32*NREQ-1:0] req_data2;
   logic [32*NREQ-1:0] req_data3;
   logic [5*NREQ-1:0]  req_select;
   logic [NREQ-1:0]    resp_valid;
   logic [NREQ-1:0]    resp_ready;
   logic [31:0]        resp_result;
   logic [31:0]        fpu_data1;
   logic [31:0]        fpu_data2;
   logic [31:0]        fpu_data3;
   logic [4:0]         fpu_select;
   logic [31:0]        fpu_result;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] cd1 [NREQ];
   logic [31:0] cd2 [NREQ];
   logic [31:0] cd3 [NREQ];
   logic [4:0]  csel[NREQ];

   always #5 clk = ~clk;

   fpu_arbiter #(.NREQ(NREQ), .BASE_CYCLES(2), .FMA_CYCLES(3), .DIV_CYCLES(6)) dut (
      .CLK(clk), .RESET(reset),
      .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_DATA1(req_data1), .REQ_DATA2(req_data2), .REQ_DATA3(req_data3),
      .REQ_SELECT(req_select),
      .RESP_VALID(resp_valid), .RESP_READY(resp_ready), .RESP_RESULT(resp_result),
      .FPU_DATA1(fpu_data1), .FPU_DATA2(fpu_data2), .FPU_DATA3(fpu_data3),
      .FPU_SELECT(fpu_select), .FPU_RESULT(fpu_result), .BUSY(busy)
   );

   // Known IEEE vectors give exact results; anything else gets an operand-dependent mix.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [4:0] s);
      if (s == 5'b00001 && a == 32'h3F800000 && b == 32'h40000000)
         fpu_model = 32'h40400000;
      else if (s == 5'b00100 && a == 32'h40C00000 && b == 32'h40000000)
         fpu_model = 32'h40400000;
      else if (s == 5'b01110 && a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000)
         fpu_model = 32'h40E00000;
      else
         fpu_model = a ^ {b[15:0], b[31:16]} ^ ~c ^ {27'd0, s};
   endfunction

   assign fpu_result = fpu_model(fpu_data1, fpu_data2, fpu_data3, fpu_select);

   function automatic logic [31:0] onehot(input int i);
      onehot = 32'd1 << i;
   endfunction

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      oh2idx = -1;
      for (int i = 0; i < NREQ; i++)
         if (v[i]) oh2idx = i;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] d3, input logic [4:0] sel);
      req_data1[32*i +: 32] = d1;
      req_data2[32*i +: 32] = d2;
      req_data3[32*i +: 32] = d3;
      req_select[5*i +: 5]  = sel;
   endtask

   // One complete transaction from a lone requester with an immediate handshake.
   task automatic do_op(input int i, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [4:0] sel, input int len,
                        input logic [31:0] exp);
      @(negedge clk);
      set_req(i, d1, d2, d3, sel);
      req_valid    = '0;
      req_valid[i] = 1'b1;
      #1;
      check("accept_ready", 32'(req_ready), onehot(i));
      check("accept_idle", 32'(busy), 32'd0);
      @(negedge clk);
      req_valid  = '0;
      resp_ready = '1;
      check("fpu_data1", fpu_data1, d1);
      check("fpu_data2", fpu_data2, d2);
      check("fpu_data3", fpu_data3, d3);
      check("fpu_select", 32'(fpu_select), 32'(sel));
      check("exec_busy", 32'(busy), 32'd1);
      check("exec_no_resp", 32'(resp_valid), 32'd0);
      for (int j = 2; j <= len; j++) begin
         @(negedge clk);
         check("exec_hold_d1", fpu_data1, d1);
         check("exec_hold_sel", 32'(fpu_select), 32'(sel));
         check("exec_no_resp", 32'(resp_valid), 32'd0);
      end
      resp_ready = '0;
      @(negedge clk);
      check("resp_valid", 32'(resp_valid), onehot(i));
      check("resp_result", resp_result, exp);
      check("resp_no_ready", 32'(req_ready), 32'd0);
      resp_ready[i] = 1'b1;
      @(negedge clk);
      resp_ready = '0;
      check("back_idle", 32'(busy), 32'd0);
      check("resp_dropped", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int last;
      int r;
      reset      = 1'b1;
      req_valid  = '0;
      resp_ready = '0;
      req_data1  = '0;
      req_data2  = '0;
      req_data3  = '0;
      req_select = '0;
      cd1[0] = 32'h11111111; cd2[0] = 32'h0F0F0000; cd3[0] = 32'h0000A5A5; csel[0] = 5'b00010;
      cd1[1] = 32'h22222222; cd2[1] = 32'h0F0F0001; cd3[1] = 32'h00014B4A; csel[1] = 5'b00011;
      cd1[2] = 32'h33333333; cd2[2] = 32'h0F0F0002; cd3[2] = 32'h00029694; csel[2] = 5'b00101;
      cd1[3] = 32'h44444444; cd2[3] = 32'h0F0F0003; cd3[3] = 32'h00052D28; csel[3] = 5'b11111;

      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_result", resp_result, 32'd0);
      check("rst_fpu_data1", fpu_data1, 32'd0);
      check("rst_fpu_select", 32'(fpu_select), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      do_op(0, 32'h3F800000, 32'h40000000, 32'h00000000, 5'b00001, 2, 32'h40400000);
      do_op(2, 32'h40C00000, 32'h40000000, 32'h00000000, 5'b00100, 6, 32'h40400000);
      do_op(1, 32'h40000000, 32'h40400000, 32'h3F800000, 5'b01110, 3, 32'h40E00000);

      // Backpressure on req0 while req1 waits.
      @(negedge clk);
      set_req(0, 32'h3F800000, 32'h40000000, 32'h00000000, 5'b00001);
      set_req(1, 32'hCAFE0001, 32'h12345678, 32'h00000011, 5'b00000);
      req_valid = 4'b0001;
      #1;
      check("bp_accept0", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 4'b0011;
      #1;
      check("bp_exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("bp_exec_ready", 32'(req_ready), 32'd0);
      resp_ready = 4'b1110;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(resp_valid), 32'd1);
         check("bp_hold_result", resp_result, 32'h40400000);
         check("bp_req1_blocked", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      resp_ready = 4'b0001;
      #1;
      check("bp_hs_valid", 32'(resp_valid), 32'd1);
      check("bp_hs_no_accept", 32'(req_ready), 32'd0);
      @(negedge clk);
      resp_ready = '0;
      #1;
      check("bp_req1_granted", 32'(req_ready), 32'd2);
      check("bp_resp_done", 32'(resp_valid), 32'd0);
      @(negedge clk);
      req_valid = '0;
      check("bp_req1_d1", fpu_data1, 32'hCAFE0001);
      @(negedge clk);
      @(negedge clk);
      check("bp_req1_valid", 32'(resp_valid), 32'd2);
      check("bp_req1_result", resp_result,
            fpu_model(32'hCAFE0001, 32'h12345678, 32'h00000011, 5'b00000));
      resp_ready = 4'b0010;
      @(negedge clk);
      resp_ready = '0;
      check("bp_idle", 32'(busy), 32'd0);

      // Continuous contention from reset with RESP_READY tied high.
      reset = 1'b1;
      #1;
      for (int i = 0; i < NREQ; i++) set_req(i, cd1[i], cd2[i], cd3[i], csel[i]);
      @(negedge clk);
      reset      = 1'b0;
      req_valid  = 4'b1111;
      resp_ready = 4'b1111;
      n    = 0;
      last = 0;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (req_ready != '0) begin
            check("cont_onehot", 32'($countones(req_ready)), 32'd1);
            check("cont_order", 32'(oh2idx(req_ready)), 32'(n % NREQ));
            if (n > 0) check("cont_spacing", 32'(c - last), 32'd4);
            last = c;
            n++;
         end
         if (resp_valid != '0) begin
            r = oh2idx(resp_valid);
            check("cont_resp_onehot", 32'($countones(resp_valid)), 32'd1);
            check("cont_result", resp_result, fpu_model(cd1[r], cd2[r], cd3[r], csel[r]));
         end
         check("cont_overlap", 32'(req_ready & resp_valid), 32'd0);
      end
      check("cont_grants", 32'(n), 32'd8);
      req_valid = '0;
      repeat (6) @(negedge clk);
      check("cont_idle", 32'(busy), 32'd0);
      resp_ready = '0;

      // Reset in the second EXEC cycle of a divide.
      @(negedge clk);
      set_req(2, 32'h40C00000, 32'h40000000, 32'h00000000, 5'b00100);
      req_valid = 4'b0100;
      #1;
      check("rx_accept", 32'(req_ready), 32'd4);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("rx_exec_busy", 32'(busy), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rx_fpu_data1", fpu_data1, 32'd0);
      check("rx_fpu_data2", fpu_data2, 32'd0);
      check("rx_fpu_select", 32'(fpu_select), 32'd0);
      check("rx_resp_result", resp_result, 32'd0);
      check("rx_resp_valid", 32'(resp_valid), 32'd0);
      check("rx_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("rx_no_resp", 32'(resp_valid), 32'd0);
         check("rx_stay_idle", 32'(busy), 32'd0);
      end
      req_valid = 4'b1001;
      #1;
      check("rx_ptr0_wins", 32'(req_ready), 32'd1);
      req_valid = 4'b1000;
      #1;
      check("rx_req3_alone", 32'(req_ready), 32'd8);
      req_valid = '0;
      do_op(3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 5'b00110, 2,
            fpu_model(32'h01020304, 32'h05060708, 32'h090A0B0C, 5'b00110));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one combinational `fpu` datapath between `NREQ` requesters, such as neuron-update engines and the CPU FP pipe, using round-robin arbitration. It latches the winning requester's operands and operation select, then holds them stable on the FPU inputs for an operation-dependent number of cycles to cover the FPU's long combinational path. It then captures the result and returns it to that requester over a valid/ready handshake. At most one operation is in flight at a time.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `BASE_CYCLES`, default 2: execute cycles for all ops except FDIV and the fused ops; legal range 1..15.
- `FMA_CYCLES`, default 3: execute cycles for FMADD, FMSUB, FNMADD and FNMSUB (select 01110..10001); legal range 1..15.
- `DIV_CYCLES`, default 6: execute cycles for FDIV (select 00100); legal range 1..15.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `REQ_VALID`  in  NREQ  request valid, one bit per requester.
- `REQ_READY`  out  NREQ  request accepted; one-hot or zero.
- `REQ_DATA1`, `REQ_DATA2`, `REQ_DATA3`  in  32*NREQ each  flattened operands; requester i occupies bits [32*i+31:32*i].
- `REQ_SELECT`  in  5*NREQ  flattened FPU op codes; requester i occupies bits [5*i+4:5*i].
- `RESP_VALID`  out  NREQ  result valid, one-hot or zero.
- `RESP_READY`  in  NREQ  requester accepts the result.
- `RESP_RESULT`  out  32  result, shared by all requesters; meaningful only where RESP_VALID is set.
- `FPU_DATA1`, `FPU_DATA2`, `FPU_DATA3`  out  32 each  registered operands driven to the fpu.
- `FPU_SELECT`  out  5  registered op code driven to the fpu.
- `FPU_RESULT`  in  32  fpu output.
- `BUSY`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE:
  - The arbiter searches REQ_VALID starting at the round-robin pointer `ptr`, wrapping upward; the first set bit is the winner `g`.
  - REQ_READY[g] is asserted combinationally in the same cycle.
  - On the clock edge, the arbiter latches g, DATA1/2/3 and SELECT of requester g into the FPU_* registers.
  - It loads the cycle counter with L-1, where L is DIV_CYCLES, FMA_CYCLES or BASE_CYCLES according to SELECT.
  - It sets `ptr` = (g+1) mod NREQ and moves to EXEC.
  - With no REQ_VALID set, the FSM stays in IDLE and REQ_READY is 0.
- EXEC:
  - FPU_* outputs are held constant.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, the arbiter captures FPU_RESULT into the RESP_RESULT register and moves to RESP.
- RESP:
  - RESP_VALID[g] is 1.
  - When RESP_READY[g] is 1, the handshake completes and the FSM moves to IDLE on that edge.
  - RESP_RESULT and RESP_VALID hold until that edge.
- Op codes:
  - Select codes not listed in the L rule, including unimplemented and illegal codes, use BASE_CYCLES.
  - The arbiter never inspects the result value.
- Pass-through:
  - FPU_* outputs keep their last values in IDLE and RESP.
  - All FPU_* outputs are 0 after reset.

## Timing
- Reset values: REQ_READY=0, RESP_VALID=0, RESP_RESULT=0, all FPU_*=0, BUSY=0, ptr=0, state=IDLE.
- Latency from accept edge to first RESP_VALID cycle is L cycles. A full transaction takes 1 + L + k cycles, where k ≥ 1 is the number of RESP cycles.
- Throughput with immediate RESP_READY is one op per L+2 cycles.
- REQ_READY depends combinationally on REQ_VALID and the state only. It never depends on RESP_READY.
- REQ_VALID may drop before it is granted; no request is remembered. A requester must hold its operands stable while REQ_VALID is high and ungranted.
- RESP_READY bits are ignored when their RESP_VALID bit is low, including in IDLE and EXEC.
- A new request cannot be accepted in the same cycle as the response handshake; acceptance occurs in the following IDLE cycle.
- Asserting RESET in any state immediately clears all registers to their reset values. An in-flight operation is dropped and produces no response.
- Arbitration is starvation-free: with continuous contention, each requester is granted at least once in every NREQ grants.

## Test plan
- Single FADD: req0, DATA1=0x3F800000, DATA2=0x40000000, SELECT=00001, with a behavioural fpu model attached and BASE_CYCLES=2. Required response: REQ_READY[0] in cycle 0, RESP_VALID[0] in cycle 2, RESP_RESULT=0x40400000.
- FDIV latency: req2, 6.0/2.0 (0x40C00000 / 0x40000000), SELECT=00100, DIV_CYCLES=6. Required response: FPU_* stable for 6 cycles, RESP_VALID[2] exactly 6 cycles after accept, result 0x40400000.
- FMADD: req1, 2.0×3.0+1.0 (DATA3=0x3F800000), SELECT=01110. Required response: RESP_RESULT=0x40E00000 after FMA_CYCLES=3 cycles.
- Contention: all four REQ_VALID held high continuously from reset, RESP_READY tied high. Required response: grant order 0,1,2,3,0,1; exactly one REQ_READY bit per accept; no RESP_VALID overlap.
- Backpressure: hold RESP_READY[0]=0 for 5 cycles while req1 is valid. Required response: RESP_VALID[0] and the result are held for 5 cycles, REQ_READY[1]=0 throughout, and req1 is granted in the first IDLE cycle after the handshake.
- Reset mid-EXEC: assert RESET in the second cycle of an FDIV. Required response: all outputs read 0 immediately, no RESP_VALID afterwards, and the next request from req3 is granted ahead of req0 only if req0 is not valid, since ptr=0.
